// File: rtl/uart_rx_if.sv
// UART receiver bundle: serial line in, frame results and debug state out.
// The receiver takes the slave side; whoever drives the line takes master.
interface uart_rx_if #(
  parameter int INPUT_DATA_WIDTH = 8
);
  logic                        serial_in;
  logic [INPUT_DATA_WIDTH-1:0] received_data;
  logic                        data_is_valid;
  logic                        rx_error;
  logic                        rx_busy;
  logic [3:0]                  state;

  modport slave (
    input  serial_in,
    output received_data,
    output data_is_valid,
    output rx_error,
    output rx_busy,
    output state
  );

  modport master (
    output serial_in,
    input  received_data,
    input  data_is_valid,
    input  rx_error,
    input  rx_busy,
    input  state
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, LSB-first data, even parity, stop.
// Mid-bit sampling behind a 3-flop synchronizer.
module uart_rx #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLOCKS_PER_BIT   = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } phase_t;

  phase_t phase_q;
  phase_t phase_d;

  logic [2:0]    sync_q;
  logic          sync_in;
  logic [TW-1:0] timer_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  shift_q;
  logic [W-1:0]  data_q;
  logic          par_err_q;
  logic          valid_q;
  logic          err_q;

  logic half_tick;
  logic bit_tick;
  logic timer_clr;
  logic stop_ok;
  logic stop_bad;

  assign sync_in   = sync_q[2];
  assign half_tick = (timer_q == HALF_LAST);
  assign bit_tick  = (timer_q == BIT_LAST);

  always_comb begin
    phase_d   = phase_q;
    timer_clr = 1'b0;
    unique case (phase_q)
      S_IDLE: begin
        timer_clr = 1'b1;
        if (!sync_in) phase_d = S_START;
      end
      S_START: begin
        if (half_tick) begin
          timer_clr = 1'b1;
          phase_d   = sync_in ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          if (idx_q == IDX_LAST) phase_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          phase_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          phase_d   = S_IDLE;
        end
      end
      default: begin
        timer_clr = 1'b1;
        phase_d   = S_IDLE;
      end
    endcase
  end

  assign stop_ok  = (phase_q == S_STOP) && bit_tick
                    && sync_in && !par_err_q;
  assign stop_bad = (phase_q == S_STOP) && bit_tick
                    && (!sync_in || par_err_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_clr ? '0 : timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx.serial_in};
      valid_q <= stop_ok;
      err_q   <= stop_bad;
      if (phase_q == S_START && half_tick) begin
        idx_q     <= '0;
        par_err_q <= 1'b0;
      end
      if (phase_q == S_DATA && bit_tick) begin
        shift_q[idx_q] <= sync_in;
        idx_q          <= idx_q + IW'(1);
      end
      // Even parity: the parity bit must equal the XOR of the data bits.
      if (phase_q == S_PARITY && bit_tick)
        par_err_q <= sync_in ^ (^shift_q);
      if (stop_ok)
        data_q <= shift_q;
    end
  end

  always_comb begin
    rx.state = 4'd0;
    unique case (phase_q)
      S_IDLE:   rx.state = 4'd0;
      S_START:  rx.state = 4'd1;
      S_DATA:   rx.state = 4'(idx_q) + 4'd2;
      S_PARITY: rx.state = 4'(W + 2);
      S_STOP:   rx.state = 4'(W + 3);
      default:  rx.state = 4'd0;
    endcase
  end

  assign rx.received_data = data_q;
  assign rx.data_is_valid = valid_q;
  assign rx.rx_error      = err_q;
  assign rx.rx_busy       = (phase_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random traffic, checked
// every cycle against a sample-schedule model of the receiver.
module tb_uart_rx;

  localparam int W   = 8;
  localparam int CPB = 8;
  localparam int H   = CPB / 2;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  uart_rx_if #(.INPUT_DATA_WIDTH(W)) bus ();

  uart_rx #(
    .INPUT_DATA_WIDTH(W),
    .CLOCKS_PER_BIT  (CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: the line is seen 3 edges late; once a start is seen at edge
  // fs, bit k is sampled at edge fs + H + (k+1)*CPB (start check at fs+H).
  logic [2:0]   m_dly   = '1;
  bit           m_idle  = 1'b1;
  int           m_edge  = 0;
  int           m_fs    = 0;
  logic [W-1:0] m_bits  = '0;
  logic         m_par   = 1'b0;
  logic [W-1:0] e_data  = '0;
  logic         e_valid = 1'b0;
  logic         e_err   = 1'b0;
  logic         e_busy  = 1'b0;
  logic [3:0]   e_state = '0;

  task automatic model_step();
    logic s;
    int   d;
    int   k;
    m_edge++;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (reset) begin
      m_dly  = '1;
      m_idle = 1'b1;
      e_data = '0;
    end else begin
      s     = m_dly[2];
      m_dly = {m_dly[1:0], bus.serial_in};
      if (m_idle) begin
        if (!s) begin
          m_idle = 1'b0;
          m_fs   = m_edge;
        end
      end else begin
        d = m_edge - m_fs;
        if (d == H) begin
          if (s) m_idle = 1'b1;
        end else if (d > H && (d - H) % CPB == 0) begin
          k = (d - H) / CPB - 1;
          if (k < W) m_bits[k] = s;
          else if (k == W) m_par = s;
          else begin
            if (s && (m_par == ^m_bits)) begin
              e_valid = 1'b1;
              e_data  = m_bits;
            end else begin
              e_err = 1'b1;
            end
            m_idle = 1'b1;
          end
        end
      end
    end
    e_busy = !m_idle;
    if (m_idle) e_state = 4'd0;
    else begin
      d = m_edge - m_fs;
      if (d < H) e_state = 4'd1;
      else begin
        k = (d - H) / CPB;
        if (k < W) e_state = 4'(k + 2);
        else e_state = 4'(W + 2);
        if (k > W) e_state = 4'(W + 3);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("valid", 32'(bus.data_is_valid), 32'(e_valid));
      chk("error", 32'(bus.rx_error), 32'(e_err));
      chk("data", 32'(bus.received_data), 32'(e_data));
      chk("busy", 32'(bus.rx_busy), 32'(e_busy));
      chk("state", 32'(bus.state), 32'(e_state));
      chk("excl", 32'(bus.data_is_valid & bus.rx_error), 32'd0);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(logic b);
    bus.serial_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(logic [W-1:0] d, logic p, logic s);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rp;
    logic         rs;
    bus.serial_in = 1'b1;
    reset         = 1'b1;
    tick(3);
    chk("rst_data", 32'(bus.received_data), 32'h0);
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_busy", 32'(bus.rx_busy), 32'h0);
    chk("rst_valid", 32'(bus.data_is_valid), 32'h0);
    reset = 1'b0;
    tick(4);

    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_valid", 32'(bus.data_is_valid), 32'h1);
    chk("a5_data", 32'(bus.received_data), 32'hA5);
    chk("a5_err", 32'(bus.rx_error), 32'h0);

    send_frame(8'h01, 1'b0, 1'b1);
    chk("par_err", 32'(bus.rx_error), 32'h1);
    chk("par_valid", 32'(bus.data_is_valid), 32'h0);
    chk("par_hold", 32'(bus.received_data), 32'hA5);

    send_frame(8'h3C, 1'b0, 1'b0);
    chk("frm_err", 32'(bus.rx_error), 32'h1);
    chk("frm_valid", 32'(bus.data_is_valid), 32'h0);
    bus.serial_in = 1'b1;
    tick(20);

    bus.serial_in = 1'b0;
    tick(2);
    bus.serial_in = 1'b1;
    tick(3);
    chk("fs_state", 32'(bus.state), 32'h1);
    chk("fs_busy", 32'(bus.rx_busy), 32'h1);
    tick(4);
    chk("fs_idle", 32'(bus.rx_busy), 32'h0);
    tick(4);

    send_frame(8'h55, 1'b0, 1'b1);
    chk("b2b_v1", 32'(bus.data_is_valid), 32'h1);
    chk("b2b_d1", 32'(bus.received_data), 32'h55);
    send_frame(8'hFF, 1'b0, 1'b1);
    chk("b2b_v2", 32'(bus.data_is_valid), 32'h1);
    chk("b2b_d2", 32'(bus.received_data), 32'hFF);
    tick(6);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bus.serial_in = 1'b0;
    tick(4);
    chk("mid_state", 32'(bus.state), 32'h5);
    reset         = 1'b1;
    bus.serial_in = 1'b1;
    tick(1);
    chk("mid_rst_st", 32'(bus.state), 32'h0);
    chk("mid_rst_d", 32'(bus.received_data), 32'h0);
    chk("mid_rst_bz", 32'(bus.rx_busy), 32'h0);
    reset = 1'b0;
    tick(5);
    send_frame(8'h81, 1'b0, 1'b1);
    chk("r81_valid", 32'(bus.data_is_valid), 32'h1);
    chk("r81_data", 32'(bus.received_data), 32'h81);

    for (int n = 0; n < 40; n++) begin
      rd = W'($urandom);
      rp = ^rd;
      if ($urandom_range(3) == 0) rp = ~rp;
      rs = ($urandom_range(7) != 0);
      if ($urandom_range(5) == 0) begin
        bus.serial_in = 1'b0;
        tick($urandom_range(1, 3));
        bus.serial_in = 1'b1;
        tick($urandom_range(6, 12));
      end
      send_frame(rd, rp, rs);
      bus.serial_in = 1'b1;
      tick(rs ? $urandom_range(0, 12) : 16);
    end

    tick(20);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter CLOCKS_PER_BIT, default 8, clk cycles per serial bit; SHALL be even and at least 4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 serial_in  input  1  asynchronous serial line; idles high.
REQ-006 received_data  output  INPUT_DATA_WIDTH  last good frame's data, registered.
REQ-007 data_is_valid  output  1  one-cycle pulse; a good frame was received.
REQ-008 rx_error  output  1  one-cycle pulse; parity or framing error.
REQ-009 rx_busy  output  1  high whenever the FSM is not IDLE.
REQ-010 state  output  4  current FSM state encoding, for formal/debug visibility.

Function
REQ-011 Frame format SHALL be 1 start bit (0), INPUT_DATA_WIDTH data bits LSB first, 1 even-parity bit equal to XOR of the data bits, and 1 stop bit (1).
REQ-012 serial_in SHALL pass through exactly 3 flip-flops before use; FSM logic SHALL read only the third stage, called sync_in.
REQ-013 FSM states SHALL be IDLE=0, START=1, DATA_0..DATA_7=2..9, PARITY=10, STOP=11; DATA states scale with INPUT_DATA_WIDTH.
REQ-014 IDLE: on sync_in==0 -> START, bit-timer cleared; otherwise remain in IDLE.
REQ-015 START: bit-timer counts to CLOCKS_PER_BIT/2-1 (mid-bit); sync_in==0 there -> DATA_0, timer cleared; sync_in==1 -> IDLE (false start), no pulses.
REQ-016 DATA_n, PARITY, STOP: sample sync_in when the timer reaches CLOCKS_PER_BIT-1, then clear the timer and advance.
REQ-017 DATA_n sample SHALL be written into shift-register bit n; received_data SHALL NOT change during reception.
REQ-018 PARITY sample SHALL be compared with XOR of the shifted data; the mismatch is latched as a pending parity error.
REQ-019 STOP sample: sync_in==1 and no parity error -> received_data loaded, data_is_valid=1 for one cycle, -> IDLE.
REQ-020 STOP sample: sync_in==0 or parity error pending -> rx_error=1 for one cycle, received_data held, data_is_valid=0, -> IDLE.
REQ-021 data_is_valid and rx_error SHALL never be high in the same cycle.
REQ-022 Latency: data_is_valid/rx_error SHALL assert CLOCKS_PER_BIT/2 + (INPUT_DATA_WIDTH+2)*CLOCKS_PER_BIT cycles after the START transition (84 at defaults), plus 3 synchronizer cycles from serial_in.
REQ-023 After STOP, a new start bit SHALL be detectable on the cycle immediately after returning to IDLE; back-to-back frames SHALL be received without loss.
REQ-024 A low serial_in while IDLE at any time, including directly after reset, SHALL be treated as a start candidate.
REQ-025 Bit-timer width SHALL be $clog2(CLOCKS_PER_BIT) bits and SHALL never wrap within a bit.

Reset
REQ-026 When reset is high: state=IDLE, timer=0, shift register=0, parity flag=0, synchronizer FFs=1, received_data=0, data_is_valid=0, rx_error=0, rx_busy=0.
REQ-027 Reset mid-frame SHALL abort the frame with no pulse; reception restarts only on a new start bit after reset is released.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-029 Frame 0xA5, parity 0, stop 1 -> data_is_valid pulse, received_data=0xA5, rx_error=0, 84 cycles after START.
REQ-030 Frame 0x01, parity 0 (wrong) -> rx_error pulse, data_is_valid=0, received_data keeps its previous value.
REQ-031 Frame 0x3C, parity 0, stop bit 0 -> rx_error pulse (framing error), no data_is_valid.
REQ-032 serial_in low for 2 cycles, then high -> START entered, then return to IDLE at mid-bit; no pulse; rx_busy deasserts.
REQ-033 Frames 0x55 then 0xFF sent back-to-back with no idle gap -> two data_is_valid pulses, data 0x55 then 0xFF.
REQ-034 Reset asserted during DATA_3 of a frame -> all outputs return to reset values next cycle; no pulse; next clean frame 0x81 received correctly.
